uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
- Shares one UART transmitter among NUM_REQ byte requesters using round-robin arbitration.
- Sequences the transmitter: presents one byte, pulses tx_valid, then times the frame internally, because the transmitter has no busy/done output.
- Sits between the host-side byte sources and the transmitter's data/tx_valid inputs, on the same t_clk/t_rst.

Parameters:
- NUM_REQ, 4: number of requesters, minimum 2.
- CLKS_PER_BIT, 16: t_clk cycles per UART bit; must match the transmitter's baud divider.
- FRAME_BITS, 10: bits per frame (start + 8 data + stop).
- GAP_CYCLES, 0: idle cycles inserted after each frame before the next grant.

Ports:
- t_clk  in  1  system clock, rising edge.
- t_rst  in  1  reset, synchronous, active-high.
- en  in  1  scheduler enable; when low, no new grants are issued.
- req_valid  in  NUM_REQ  per-requester byte-available flag.
- req_data  in  8*NUM_REQ  requester i owns bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- tx_data  out  8  byte to the transmitter data input.
- tx_valid  out  1  one-cycle start pulse to the transmitter.
- tx_busy  out  1  high from the LOAD cycle until the frame and gap complete.
- grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester.
- frames_sent  out  16  count of frames launched; wraps at 0xFFFF->0.

Behaviour:
- Reset, synchronous on t_rst=1:
  - state=IDLE.
  - req_ready=0, tx_valid=0, tx_data=0x00, tx_busy=0, grant_id=0, frames_sent=0.
  - Round-robin pointer=0, frame counter=0.
  - Reset mid-frame aborts immediately with no completion of the frame.
- States:
  - IDLE:
    - If en=1 and any req_valid: select the first valid index scanning upward from the pointer, with wrap-around.
    - Register that index into grant_id and go to LOAD.
    - Otherwise stay in IDLE.
  - LOAD (1 cycle):
    - If req_valid[grant_id]=1: req_ready[grant_id]=1, tx_valid=1, tx_data <= req_data[grant_id].
    - Pointer <= (grant_id+1) mod NUM_REQ; frames_sent increments; go to SEND.
    - If req_valid[grant_id]=0 (requester withdrew): no ready, no tx_valid, pointer unchanged, return to IDLE.
  - SEND:
    - Frame counter counts CLKS_PER_BIT*FRAME_BITS cycles, starting the cycle after LOAD.
    - tx_data is held stable for the whole frame.
    - On the terminal count: go to GAP if GAP_CYCLES>0, else IDLE.
  - GAP: counts GAP_CYCLES cycles, then goes to IDLE.
- Latency:
  - req_valid seen in IDLE -> req_ready/tx_valid exactly 1 cycle later (LOAD).
  - Frame-to-frame spacing: the LOAD of the next frame occurs CLKS_PER_BIT*FRAME_BITS + GAP_CYCLES + 1 cycles after the previous LOAD.
- Handshake:
  - A requester holds req_valid and its data stable until it sees req_ready.
  - The byte transfers in the req_ready cycle.
  - req_ready is never asserted outside LOAD, and never on more than one bit.
- tx_busy = (state != IDLE).
- en=0 during SEND or GAP does not stop the in-flight frame; it only blocks the next IDLE grant.
- Simultaneous requests:
  - The pointer guarantees that each continuously-valid requester is served within NUM_REQ frames.
  - A requester asserting valid in the same cycle another is granted waits for the next IDLE.
- Counter widths:
  - Frame counter is clog2(CLKS_PER_BIT*FRAME_BITS) bits.
  - Gap counter is max(1,clog2(GAP_CYCLES+1)) bits.
  - Pointer arithmetic is mod NUM_REQ, correct for non-power-of-2 NUM_REQ.

Decomposition:
- Shared package uart_pkg:
  - state enum sched_state_t {IDLE, LOAD, SEND, GAP}.
  - Localparam UART_DATA_W=8 and default FRAME_BITS=10, for reuse by the transmitter and receiver.
- One sub-module, rr_arbiter:
  - Combinational priority select from req vector plus pointer.
  - Outputs a grant index and an any_req flag.
  - Pointer register stays in the scheduler.

Test Plan:
- Use CLKS_PER_BIT=4, FRAME_BITS=10, GAP_CYCLES=0 (40-cycle frames) unless stated.
- Single requester: req_valid=0001, req_data[7:0]=0xDD -> req_ready[0] and tx_valid pulse 1 cycle after request; tx_data=0xDD held 40 cycles; tx_busy high 41 cycles; frames_sent=1.
- All four valid continuously, bytes 0xA0..0xA3 -> grant order 0,1,2,3,0; LOADs spaced 41 cycles apart; tx_data sequence A0,A1,A2,A3,A0.
- Requester 2 withdraws valid in the cycle after IDLE grants it -> no req_ready, no tx_valid; scheduler returns to IDLE; pointer still 2; frames_sent unchanged.
- en dropped mid-SEND with requester 1 pending -> current frame completes (tx_busy falls at terminal count); no new LOAD until en=1; grant 1 one cycle after IDLE sees en.
- t_rst asserted 15 cycles into SEND -> next cycle all outputs at reset values, state IDLE, pointer 0; a pending request is granted 1 cycle after t_rst deasserts.
- GAP_CYCLES=3 with requester 0 continuously valid -> consecutive LOADs 44 cycles apart; frames_sent wraps 0xFFFF->0x0000 when preloaded via force.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler state encoding, data width, default frame
// length and a small modular-increment helper for round-robin pointers.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FRAME_BITS = 10;   // start + 8 data + stop

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        GAP
    } sched_state_t;

    // (idx + 1) mod n without a divider; idx is assumed to be below n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Byte-request side and transmitter side of the scheduler, bundled together.
// master = scheduler, slave = the requesters plus the transmitter.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    import uart_pkg::*;

    logic [NUM_REQ-1:0]             req_valid;
    logic [UART_DATA_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic [UART_DATA_W-1:0]         tx_data;
    logic                           tx_valid;

    modport master (
        input  req_valid, req_data,
        output req_ready, tx_data, tx_valid
    );

    modport slave (
        output req_valid, req_data,
        input  req_ready, tx_data, tx_valid
    );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin select: first asserted request at or above the
// pointer, wrapping past the top index. Pointer storage lives in the caller.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_grant,
    output logic               o_any_req
);

    logic [IDX_W-1:0]   w_idx [NUM_REQ];
    logic [NUM_REQ-1:0] w_hit;

    // Rotated index for each scan offset, reduced mod NUM_REQ by one subtract.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [IDX_W:0] w_sum;
            assign w_sum      = {1'b0, i_ptr} + (IDX_W+1)'(gi);
            assign w_idx[gi]  = (w_sum >= (IDX_W+1)'(NUM_REQ)) ?
                                IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ)) : IDX_W'(w_sum);
            assign w_hit[gi]  = i_req[w_idx[gi]];
        end
    endgenerate

    assign o_any_req = |i_req;

    // Scan from the far offset down so the nearest hit to the pointer wins.
    always_comb begin
        o_grant = w_idx[0];
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                o_grant = w_idx[k];
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte
// sources. The transmitter has no busy output, so frame time is counted here.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int CLKS_PER_BIT = 16,
    parameter  int FRAME_BITS   = UART_FRAME_BITS,
    parameter  int GAP_CYCLES   = 0,
    localparam int IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  t_clk,
    input  logic                  t_rst,
    input  logic                  en,
    uart_tx_scheduler_if.master   bus,
    output logic                  tx_busy,
    output logic [IDX_W-1:0]      grant_id,
    output logic [15:0]           frames_sent
);

    localparam int FRAME_CYC = CLKS_PER_BIT * FRAME_BITS;
    localparam int CNT_W     = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
    localparam int GAP_W     = (GAP_CYCLES > 0) ? (($clog2(GAP_CYCLES + 1) > 0) ? $clog2(GAP_CYCLES + 1) : 1) : 1;

    sched_state_t          r_state;
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_grant;
    logic [15:0]           r_frames;
    logic [UART_DATA_W-1:0] r_tx_data;
    logic [CNT_W-1:0]      r_cnt;
    logic [GAP_W-1:0]      r_gap;

    logic [IDX_W-1:0]       w_arb_grant;
    logic                   w_any_req;
    logic                   w_sel_valid;
    logic [UART_DATA_W-1:0] w_sel_data;
    logic                   w_launch;
    logic                   w_frame_done;
    logic                   w_gap_done;
    logic                   w_arb_slot;
    logic                   w_grant_now;
    logic [NUM_REQ-1:0]     w_ready;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req     (bus.req_valid),
        .i_ptr     (r_ptr),
        .o_grant   (w_arb_grant),
        .o_any_req (w_any_req)
    );

    assign w_sel_valid  = bus.req_valid[r_grant];
    assign w_sel_data   = bus.req_data[r_grant*UART_DATA_W +: UART_DATA_W];
    // A requester may withdraw between grant and LOAD, so the launch decision
    // must look at its live valid rather than a registered copy.
    assign w_launch     = (r_state == LOAD) && w_sel_valid;
    assign w_frame_done = (r_state == SEND) && (r_cnt == CNT_W'(FRAME_CYC - 1));
    assign w_gap_done   = (r_state == GAP)  && (r_gap == GAP_W'(GAP_CYCLES - 1));
    // The final cycle of a frame (or gap) doubles as the arbitration cycle, so
    // back-to-back LOADs sit exactly FRAME_CYC + GAP_CYCLES + 1 cycles apart.
    assign w_arb_slot   = (r_state == IDLE) ||
                          (w_frame_done && (GAP_CYCLES == 0)) || w_gap_done;
    assign w_grant_now  = w_arb_slot && en && w_any_req;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign w_ready[gi] = w_launch && (r_grant == IDX_W'(gi));
        end
    endgenerate

    assign bus.req_ready = w_ready;
    assign bus.tx_valid  = w_launch;
    // Present the live byte alongside tx_valid; the registered copy holds it
    // steady for the rest of the frame.
    assign bus.tx_data   = w_launch ? w_sel_data : r_tx_data;
    assign tx_busy       = (r_state != IDLE);
    assign grant_id      = r_grant;
    assign frames_sent   = r_frames;

    // Scheduler FSM: grant, launch one byte, then time the frame and gap.
    always_ff @(posedge t_clk) begin
        if (t_rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_frames  <= '0;
            r_tx_data <= '0;
            r_cnt     <= '0;
            r_gap     <= '0;
        end else begin
            case (r_state)
                IDLE: ;
                LOAD: begin
                    if (w_sel_valid) begin
                        r_ptr     <= IDX_W'(wrap_inc(32'(r_grant), NUM_REQ));
                        r_frames  <= r_frames + 16'd1;
                        r_tx_data <= w_sel_data;
                        r_cnt     <= '0;
                        r_state   <= SEND;
                    end else begin
                        r_state   <= IDLE;
                    end
                end
                SEND: begin
                    if (w_frame_done) begin
                        r_gap   <= '0;
                        r_state <= (GAP_CYCLES > 0) ? GAP : IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (w_gap_done) begin
                        r_state <= IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_grant_now) begin
                r_grant <= w_arb_grant;
                r_state <= LOAD;
            end
        end
    end

endmodule
